// File: rtl/rr_bus_arbiter.sv
// rr_bus_arbiter
//   Round-robin arbiter sharing one single-transaction resource between N
//   requesters. A grant is locked until the resource pulses done, after which
//   priority rotates past the served requester. An optional watchdog forces a
//   release when done never arrives.
//
// Parameters
//   N        number of requesters (power of two, 2..32)
//   LogN     derived; grant_id is LogN+1 bits wide
//   TIMEOUT  cycles a grant may be held without done; 0 disables the watchdog
//
// Ports
//   clock     system clock, rising edge
//   reset_n   synchronous active-low reset
//   req       per-requester request levels
//   done      completion pulse for the granted transaction
//   grant     registered one-hot grant, zero when idle
//   grant_id  binary index of the granted requester, zero when idle
//   busy      high while a grant is held
//   timeout   one-cycle pulse following a watchdog release
module rr_bus_arbiter #(
    parameter int N       = 4,
    parameter int LogN    = $clog2(N) - 1,
    parameter int TIMEOUT = 255
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [N-1:0]    req,
    input  logic            done,
    output logic [N-1:0]    grant,
    output logic [LogN:0]   grant_id,
    output logic            busy,
    output logic            timeout
);

    // Keep the counter at least one bit wide so TIMEOUT=0 still elaborates;
    // it then never leaves zero.
    localparam int CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state, state_nx;
    logic [N-1:0]    grant_nx;
    logic [LogN:0]   id_nx;
    logic [LogN:0]   last, last_nx;
    logic [LogN:0]   winner;
    logic [CW-1:0]   cnt, cnt_nx;
    logic            to_nx;
    logic            found;
    logic            expire;

    // Winner: lowest requester above the last-served index, else wrap to the
    // lowest requester overall.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && req[i] && (i > 32'(last))) begin
                winner = i[LogN:0];
                found  = 1'b1;
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && req[i]) begin
                winner = i[LogN:0];
                found  = 1'b1;
            end
        end
    end

    assign expire = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));

    always_comb begin
        state_nx = state;
        grant_nx = grant;
        id_nx    = grant_id;
        last_nx  = last;
        cnt_nx   = cnt;
        to_nx    = 1'b0;
        unique case (state)
            IDLE: begin
                if (|req) begin
                    grant_nx = N'(1) << winner;
                    id_nx    = winner;
                    cnt_nx   = '0;
                    state_nx = GRANT;
                end
            end
            GRANT: begin
                if (done || expire) begin
                    // done takes precedence, so timeout only pulses when the
                    // watchdog alone ends the grant.
                    to_nx    = !done;
                    last_nx  = grant_id;
                    grant_nx = '0;
                    id_nx    = '0;
                    state_nx = IDLE;
                end else if (TIMEOUT != 0) begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= IDLE;
            grant    <= '0;
            grant_id <= '0;
            last     <= '1;
            cnt      <= '0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nx;
            grant    <= grant_nx;
            grant_id <= id_nx;
            last     <= last_nx;
            cnt      <= cnt_nx;
            timeout  <= to_nx;
        end
    end

    assign busy = |grant;

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Self-checking bench for rr_bus_arbiter (N=4, TIMEOUT=4).
module tb_rr_bus_arbiter;
    localparam int N  = 4;
    localparam int TO = 4;

    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] req     = '0;
    logic       done    = 1'b0;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       busy;
    logic       timeout;
    logic [7:0] obs;

    int tests  = 0;
    int fails  = 0;
    int m_last = N - 1;

    rr_bus_arbiter #(.N(N), .TIMEOUT(TO)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .req      (req),
        .done     (done),
        .grant    (grant),
        .grant_id (grant_id),
        .busy     (busy),
        .timeout  (timeout)
    );

    always #5 clock = ~clock;

    assign obs = {grant, grant_id, busy, timeout};

    // Next requester after 'last' going round the ring.
    function automatic int rr_pick(int last, logic [3:0] r);
        for (int off = 1; off <= N; off++) begin
            int idx;
            idx = (last + off) % N;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    // Expected {grant, grant_id, busy, timeout}.
    function automatic logic [7:0] ev(bit g, int id, bit to);
        logic [3:0] oh;
        logic [1:0] bid;
        oh  = g ? 4'(1 << id) : 4'b0000;
        bid = g ? 2'(id) : 2'b00;
        return {oh, bid, g, to};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        m_last  = N - 1;
    endtask

    task automatic test_reset();
        logic [7:0] e;
        reset_n = 1'b0; req = 4'b1111; done = 1'b1;
        tick(); tick();
        e = ev(0, 0, 0);
        tests++;
        if (obs !== e) begin fails++; $display("FAIL reset_state: got %b expected %b", obs, e); end
        reset_n = 1'b1; req = '0; done = 1'b0; m_last = N - 1;
        tick();
        tests++;
        if (obs !== e) begin fails++; $display("FAIL reset_idle: got %b expected %b", obs, e); end
    endtask

    task automatic test_basic();
        logic [7:0] e;
        int id;
        req = 4'b1010;
        id  = rr_pick(m_last, req);
        tick();
        e = ev(1, id, 0);
        tests++;
        if (obs !== e) begin fails++; $display("FAIL basic_grant: got %b expected %b", obs, e); end
        req = '0;
        tick();
        tests++;
        if (obs !== e) begin fails++; $display("FAIL basic_hold: got %b expected %b", obs, e); end
        done = 1'b1;
        tick();
        done = 1'b0;
        m_last = id;
        e = ev(0, 0, 0);
        tests++;
        if (obs !== e) begin fails++; $display("FAIL basic_release: got %b expected %b", obs, e); end
    endtask

    task automatic test_fairness();
        logic [7:0] e;
        int id;
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            id = rr_pick(m_last, req);
            tick();
            e = ev(1, k % N, 0);
            tests++;
            if (obs !== e || id != k % N) begin
                fails++; $display("FAIL fair_grant%0d: got %b expected %b", k, obs, e);
            end
            tick();
            tests++;
            if (obs !== e) begin fails++; $display("FAIL fair_hold%0d: got %b expected %b", k, obs, e); end
            done = 1'b1;
            tick();
            done = 1'b0;
            m_last = k % N;
            e = ev(0, 0, 0);
            tests++;
            if (obs !== e) begin fails++; $display("FAIL fair_idle%0d: got %b expected %b", k, obs, e); end
        end
        req = '0;
        tick();
    endtask

    task automatic test_wrap();
        logic [7:0] e;
        logic [3:0] pats [3] = '{4'b0100, 4'b0011, 4'b1001};
        int id;
        for (int p = 0; p < 3; p++) begin
            req = pats[p];
            id  = rr_pick(m_last, req);
            tick();
            e = ev(1, id, 0);
            tests++;
            if (obs !== e) begin fails++; $display("FAIL wrap_grant%0d: got %b expected %b", p, obs, e); end
            done = 1'b1; req = '0;
            tick();
            done = 1'b0;
            m_last = id;
            e = ev(0, 0, 0);
            tests++;
            if (obs !== e) begin fails++; $display("FAIL wrap_release%0d: got %b expected %b", p, obs, e); end
        end
        // From last=2, 0011 must wrap to 0; from last=0, 1001 must pick 3.
        tests++;
        if (m_last != 3 || rr_pick(2, 4'b0011) != 0) begin
            fails++; $display("FAIL wrap_model: got %0d expected 3", m_last);
        end
    endtask

    task automatic test_timeout();
        logic [7:0] e;
        req = 4'b0100;
        tick();
        e = ev(1, 2, 0);
        tests++;
        if (obs !== e) begin fails++; $display("FAIL to_grant: got %b expected %b", obs, e); end
        req = '0;
        for (int c = 1; c < TO; c++) begin
            tick();
            tests++;
            if (obs !== e) begin fails++; $display("FAIL to_hold%0d: got %b expected %b", c, obs, e); end
        end
        tick();
        e = ev(0, 0, 1);
        tests++;
        if (obs !== e) begin fails++; $display("FAIL to_pulse: got %b expected %b", obs, e); end
        m_last = 2;
        tick();
        e = ev(0, 0, 0);
        tests++;
        if (obs !== e) begin fails++; $display("FAIL to_pulse_end: got %b expected %b", obs, e); end
        req = 4'b0100;
        tick();
        e = ev(1, 2, 0);
        tests++;
        if (obs !== e) begin fails++; $display("FAIL to_regrant: got %b expected %b", obs, e); end
        done = 1'b1; req = '0;
        tick();
        done = 1'b0;
        m_last = 2;
    endtask

    task automatic test_lock();
        logic [7:0] e;
        req = 4'b0010;
        tick();
        e = ev(1, 1, 0);
        tests++;
        if (obs !== e) begin fails++; $display("FAIL lock_grant: got %b expected %b", obs, e); end
        req = 4'b0001;
        for (int c = 1; c < TO; c++) begin
            tick();
            tests++;
            if (obs !== e) begin fails++; $display("FAIL lock_hold%0d: got %b expected %b", c, obs, e); end
        end
        // done lands on the same edge as watchdog expiry.
        done = 1'b1; req = '0;
        tick();
        done = 1'b0;
        m_last = 1;
        e = ev(0, 0, 0);
        tests++;
        if (obs !== e) begin fails++; $display("FAIL lock_done_vs_expiry: got %b expected %b", obs, e); end
        tick();
        tests++;
        if (obs !== e) begin fails++; $display("FAIL lock_no_pulse: got %b expected %b", obs, e); end
    endtask

    task automatic test_reset_mid_grant();
        logic [7:0] e;
        req = 4'b0001;
        tick();
        done = 1'b1; req = '0;
        tick();
        done = 1'b0;
        m_last = 0;
        req = 4'b1000;
        tick();
        e = ev(1, 3, 0);
        tests++;
        if (obs !== e) begin fails++; $display("FAIL rst_mid_grant: got %b expected %b", obs, e); end
        req = '0; reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        m_last = N - 1;
        e = ev(0, 0, 0);
        tests++;
        if (obs !== e) begin fails++; $display("FAIL rst_mid_drop: got %b expected %b", obs, e); end
        req = 4'b1001;
        tick();
        e = ev(1, rr_pick(m_last, 4'b1001), 0);
        tests++;
        if (obs !== e) begin fails++; $display("FAIL rst_mid_regrant: got %b expected %b", obs, e); end
        done = 1'b1; req = '0;
        tick();
        done = 1'b0;
        m_last = 0;
        req = 4'b1000;
        tick();
        e = ev(1, 3, 0);
        tests++;
        if (obs !== e) begin fails++; $display("FAIL rst_mid_req3: got %b expected %b", obs, e); end
        done = 1'b1; req = '0;
        tick();
        done = 1'b0;
        m_last = 3;
    endtask

    task automatic test_random(int rounds);
        logic [7:0] e;
        logic [3:0] r;
        int id, d, rel;
        bit to;
        for (int n = 0; n < rounds; n++) begin
            r   = 4'($urandom_range(1, 15));
            req = r;
            id  = rr_pick(m_last, r);
            tick();
            e = ev(1, id, 0);
            tests++;
            if (obs !== e) begin fails++; $display("FAIL rnd_grant%0d: got %b expected %b", n, obs, e); end
            // d = cycle at which done is sampled; the watchdog ends it at TO.
            d   = $urandom_range(1, TO + 2);
            rel = (d <= TO) ? d : TO;
            to  = (d > TO);
            for (int c = 1; c <= rel; c++) begin
                req = 4'($urandom_range(0, 15));
                if (c == d) done = 1'b1;
                tick();
                done = 1'b0;
                e = (c < rel) ? ev(1, id, 0) : ev(0, 0, to);
                tests++;
                if (obs !== e) begin
                    fails++; $display("FAIL rnd_cycle%0d_%0d: got %b expected %b", n, c, obs, e);
                end
            end
            m_last = id;
            req  = '0;
            done = 1'($urandom_range(0, 1));
            tick();
            done = 1'b0;
            e = ev(0, 0, 0);
            tests++;
            if (obs !== e) begin fails++; $display("FAIL rnd_idle%0d: got %b expected %b", n, obs, e); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fairness();
        test_wrap();
        test_timeout();
        test_lock();
        test_reset_mid_grant();
        test_random(40);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rr_bus_arbiter.md
Name: rr_bus_arbiter

Overview:
- Round-robin arbiter that shares one single-transaction resource between N requesters, for example a memory/bus port used by the fetch unit, the LSU and the FPU load/store path.
- Selects one requester, holds the grant until the resource signals completion, then rotates priority past the served requester.
- A watchdog releases a grant whose transaction never completes.

Parameters:
- N, 4, number of requesters; power of two, 2 to 32.
- LogN, $clog2(N)-1, derived; the ID width is LogN+1.
- TIMEOUT, 255, cycles a grant may be held without done before forced release; 0 disables the watchdog.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- req  input  N  per-requester request level; a requester holds it high until granted.
- done  input  1  resource completion pulse for the current granted transaction.
- grant  output  N  one-hot grant, registered; all-zero when idle.
- grant_id  output  LogN+1  binary index of the granted requester; 0 when idle.
- busy  output  1  high while a grant is held (equals |grant).
- timeout  output  1  one-cycle pulse when the watchdog forces a release.

Behaviour:
- Reset (reset_n low at an edge):
  - state=IDLE, grant=0, grant_id=0, busy=0, timeout=0, watchdog counter=0.
  - Last-served pointer last=N-1, so the first arbitration favours index 0.
  - Reset mid-grant drops the grant on that edge, with no timeout pulse.
- FSM states are IDLE and GRANT.
- IDLE:
  - If |req, compute masked = req bits with index > last.
  - Winner = lowest set index of masked if masked≠0, else lowest set index of req.
  - On the same edge: grant=onehot(winner), grant_id=winner, busy=1, counter=0, state=GRANT.
  - Latency: req high before edge k gives grant visible after edge k (1 cycle).
  - If req=0, stay in IDLE.
- GRANT:
  - Grant is locked: changes on req, including the granted requester dropping its req, are ignored.
  - done=1 at an edge: last=grant_id, grant=0, grant_id=0, busy=0, state=IDLE.
  - At least one idle cycle always separates consecutive grants; there is no back-to-back re-grant.
  - done with TIMEOUT expiry on the same edge: done wins and timeout is not pulsed.
  - Else, if TIMEOUT≠0 and counter==TIMEOUT-1: the same release as done, plus timeout=1 for one cycle and last=grant_id.
  - Else counter increments; it must not wrap before TIMEOUT.
- done in IDLE is ignored.
- timeout is 0 in every cycle except the cycle following a forced release.
- Counter width is $clog2(TIMEOUT+1); with TIMEOUT=0 the counter logic is constant and timeout is tied to 0.
- Fairness: with all req held high, grants cycle 0,1,…,N-1,0,… with no requester skipped.
- Invariant: grant is always one-hot or zero, and grant_id matches grant.

Test Plan:
- Reset then req=4'b1010 → after 1 edge grant=4'b0010, grant_id=1, busy=1; done pulse → grant=0 next edge, last=1.
- req=4'b1111 held, done pulsed 2 cycles after each grant → grant_id sequence 0,1,2,3,0, each separated by one idle cycle.
- last=2, req=4'b0011 → masked empty, wrap to grant_id=0; then req=4'b1001 with last=0 → grant_id=3.
- TIMEOUT=4, grant to 2, no done → grant drops 4 cycles after grant, timeout=1 for exactly 1 cycle; next req=4'b0100 → grant_id=2 (only requester).
- During GRANT to 1: req changes to 4'b0001 and req[1] drops → grant stays 4'b0010 until done; done and expiry on the same edge → timeout stays 0.
- reset_n low for one edge while grant=4'b1000 → grant=0, busy=0, timeout=0; req=4'b1000 then regranted with last reset to N-1 (i.e. index 0 favoured).
